// File: rtl/pll_reset_seq.sv
// Holds the PLL clock domain in reset until lock has been stable and a hold time has elapsed,
// then runs microsecond/millisecond enable ticks. Outputs are registered from next-state.
module pll_reset_seq #(
    parameter int CLK_MHZ     = 20,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int MS_DIV      = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_lock,
    output logic out_reset,
    output logic ready,
    output logic tick_us,
    output logic tick_ms
);

    localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int UW = (CLK_MHZ     > 1) ? $clog2(CLK_MHZ)     : 1;
    localparam int MW = (MS_DIV      > 1) ? $clog2(MS_DIV)      : 1;

    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [UW-1:0] US_MAX   = UW'(CLK_MHZ - 1);
    localparam logic [MW-1:0] MS_MAX   = MW'(MS_DIV - 1);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_lock_s;
    logic [FW-1:0] r_filt_cnt;
    logic [FW-1:0] w_filt_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic [UW-1:0] r_us_cnt;
    logic [UW-1:0] w_us_nxt;
    logic [MW-1:0] r_ms_cnt;
    logic [MW-1:0] w_ms_nxt;
    logic          w_tick_us_nxt;
    logic          w_tick_ms_nxt;
    logic          r_out_reset;
    logic          r_ready;
    logic          r_tick_us;
    logic          r_tick_ms;

    // pll_lock is asynchronous to clock; two flops before anything looks at it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s = r_sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RESET;
            r_filt_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_us_cnt    <= '0;
            r_ms_cnt    <= '0;
            r_tick_us   <= 1'b0;
            r_tick_ms   <= 1'b0;
            r_out_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_filt_cnt  <= w_filt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_us_cnt    <= w_us_nxt;
            r_ms_cnt    <= w_ms_nxt;
            r_tick_us   <= w_tick_us_nxt;
            r_tick_ms   <= w_tick_ms_nxt;
            r_out_reset <= (w_state_nxt != ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
        end
    end

    // Tick counters default to 0 so they are held cleared in every state but RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_filt_nxt    = r_filt_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_us_nxt      = '0;
        w_ms_nxt      = '0;
        w_tick_us_nxt = 1'b0;
        w_tick_ms_nxt = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_filt_nxt  = '0;
                w_hold_nxt  = '0;
            end

            ST_WAIT_LOCK: begin
                if (!w_lock_s) begin
                    w_filt_nxt = '0;
                end else if (r_filt_cnt == FILT_MAX) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = '0;
                end else begin
                    w_filt_nxt = r_filt_cnt + FW'(1);
                end
            end

            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_filt_nxt  = '0;
                end else if (r_hold_cnt == HOLD_MAX) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end

            ST_RUN: begin
                // Lock loss takes priority over a tick wrap on the same edge.
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_filt_nxt  = '0;
                    w_hold_nxt  = '0;
                end else if (r_us_cnt == US_MAX) begin
                    w_tick_us_nxt = 1'b1;
                    if (r_ms_cnt == MS_MAX) begin
                        w_tick_ms_nxt = 1'b1;
                    end else begin
                        w_ms_nxt = r_ms_cnt + MW'(1);
                    end
                end else begin
                    w_us_nxt = r_us_cnt + UW'(1);
                    w_ms_nxt = r_ms_cnt;
                end
            end

            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    assign out_reset = r_out_reset;
    assign ready     = r_ready;
    assign tick_us   = r_tick_us;
    assign tick_ms   = r_tick_ms;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: a default instance and a minimal-parameter instance share stimulus and
// are compared every cycle against a model based on the length of the current synchronized lock run.
module tb_pll_reset_seq;

    localparam int D_CM = 20, D_LF = 16, D_HC = 1024, D_MD = 1000;
    localparam int S_CM = 2,  S_LF = 1,  S_HC = 1,    S_MD = 2;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic d_out_reset, d_ready, d_tick_us, d_tick_ms;
    logic s_out_reset, s_ready, s_tick_us, s_tick_ms;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(.CLK_MHZ(D_CM), .LOCK_FILTER(D_LF), .HOLD_CYCLES(D_HC), .MS_DIV(D_MD)) u_dut (
        .clock(clk), .reset(rst), .pll_lock(pll_lock),
        .out_reset(d_out_reset), .ready(d_ready), .tick_us(d_tick_us), .tick_ms(d_tick_ms)
    );

    pll_reset_seq #(.CLK_MHZ(S_CM), .LOCK_FILTER(S_LF), .HOLD_CYCLES(S_HC), .MS_DIV(S_MD)) u_dut_s (
        .clock(clk), .reset(rst), .pll_lock(pll_lock),
        .out_reset(s_out_reset), .ready(s_ready), .tick_us(s_tick_us), .tick_ms(s_tick_ms)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the FSM sees pll_lock two edges late; the design is in RUN once the run of
    // consecutive seen-high samples reaches LOCK_FILTER+HOLD_CYCLES, and ticks are multiples of
    // the run length beyond that point.
    function automatic logic [3:0] model_out(input int c, input int lf, input int hc,
                                             input int cm, input int md);
        int   r;
        logic rdy, tu, tm;
        r   = c - (lf + hc);
        rdy = (r >= 0);
        tu  = rdy && (r > 0) && ((r % cm) == 0);
        tm  = tu && ((r % (cm * md)) == 0);
        return {~rdy, rdy, tu, tm};
    endfunction

    logic hist[$];
    logic seen;
    int   c_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  = {1'b0, 1'b0};
            c_run = 0;
        end else begin
            hist.push_back(pll_lock);
            seen  = hist.pop_front();
            c_run = seen ? c_run + 1 : 0;
        end
    end

    logic [3:0] ed, es;

    always @(negedge clk) begin
        ed = model_out(c_run, D_LF, D_HC, D_CM, D_MD);
        es = model_out(c_run, S_LF, S_HC, S_CM, S_MD);
        chk("def_out_reset", int'(d_out_reset), int'(ed[3]));
        chk("def_ready",     int'(d_ready),     int'(ed[2]));
        chk("def_tick_us",   int'(d_tick_us),   int'(ed[1]));
        chk("def_tick_ms",   int'(d_tick_ms),   int'(ed[0]));
        chk("sml_out_reset", int'(s_out_reset), int'(es[3]));
        chk("sml_ready",     int'(s_ready),     int'(es[2]));
        chk("sml_tick_us",   int'(s_tick_us),   int'(es[1]));
        chk("sml_tick_ms",   int'(s_tick_ms),   int'(es[0]));
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_def_out_reset"}, int'(d_out_reset), 1);
        chk({tag, "_def_ready"},     int'(d_ready),     0);
        chk({tag, "_def_tick_us"},   int'(d_tick_us),   0);
        chk({tag, "_def_tick_ms"},   int'(d_tick_ms),   0);
        chk({tag, "_sml_out_reset"}, int'(s_out_reset), 1);
        chk({tag, "_sml_ready"},     int'(s_ready),     0);
    endtask

    // Release reset just after an edge and return the edge number at which ready rose.
    task automatic release_and_measure(output int k_def, output int k_sml);
        rst   = 1'b0;
        k_def = 0;
        k_sml = 0;
        for (int k = 1; k <= 3000; k++) begin
            edge_step();
            if (k_sml == 0 && s_ready) k_sml = k;
            if (d_ready) begin
                k_def = k;
                break;
            end
        end
    endtask

    // Assert reset between edges and check outputs before any edge arrives.
    task automatic async_reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        edge_step();
    endtask

    initial begin
        int kd, ks, ka, kr, n_us, n_ms, n_sus, n_sms, hi, lo;

        rst      = 1'b1;
        pll_lock = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) edge_step();

        release_and_measure(kd, ks);
        chk("release_edge_def", kd, 1042);
        chk("release_edge_sml", ks, 4);

        n_us = 0; n_ms = 0; n_sus = 0; n_sms = 0;
        for (int k = 1; k <= 50000; k++) begin
            edge_step();
            n_us  += int'(d_tick_us);
            n_ms  += int'(d_tick_ms);
            n_sus += int'(s_tick_us);
            n_sms += int'(s_tick_ms);
        end
        chk("run_tick_us_count",     n_us,  2500);
        chk("run_tick_ms_count",     n_ms,  2);
        chk("run_sml_tick_us_count", n_sus, 25000);
        chk("run_sml_tick_ms_count", n_sms, 12500);

        // One-cycle lock drop in RUN, then measure assertion and relock latency.
        pll_lock = 1'b0;
        ka = 0;
        kr = 0;
        for (int k = 1; k <= 1200; k++) begin
            edge_step();
            if (k == 1) pll_lock = 1'b1;
            if (ka == 0 && d_out_reset) ka = k;
            if (ka != 0 && !d_out_reset) begin
                kr = k;
                break;
            end
        end
        chk("lockloss_assert_edge", ka, 3);
        chk("relock_edges_from_rise", kr - 1, 1042);

        // Lock glitch during the filter window restarts the filter.
        async_reset_pulse("glitch");
        rst = 1'b0;
        kd  = 0;
        for (int k = 1; k <= 3000; k++) begin
            edge_step();
            if (k == 10) pll_lock = 1'b0;
            if (k == 11) pll_lock = 1'b1;
            if (d_ready) begin
                kd = k;
                break;
            end
        end
        chk("glitch_release_edge", kd, 1053);

        // Reset mid-HOLD (hold count 500) and again mid-RUN while a tick is high.
        async_reset_pulse("pre_hold");
        rst = 1'b0;
        repeat (518) edge_step();
        async_reset_pulse("mid_hold");
        release_and_measure(kd, ks);
        chk("rerelease_edge_def", kd, 1042);
        kd = 0;
        for (int k = 1; k <= 40; k++) begin
            edge_step();
            if (d_tick_us) begin
                kd = 1;
                break;
            end
        end
        chk("found_tick_before_reset", kd, 1);
        async_reset_pulse("mid_run");
        release_and_measure(kd, ks);
        chk("release_after_run_reset", kd, 1042);

        // Random lock patterns, with occasional async reset pulses.
        for (int seg = 0; seg < 30; seg++) begin
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1030, 1100))
                                              : int'($urandom_range(1, 40));
            lo = int'($urandom_range(1, 4));
            pll_lock = 1'b1;
            repeat (hi) edge_step();
            pll_lock = 1'b0;
            repeat (lo) edge_step();
            if ($urandom_range(0, 7) == 0) begin
                async_reset_pulse("rand");
                repeat ($urandom_range(0, 2)) edge_step();
                rst = 1'b0;
            end
        end
        pll_lock = 1'b1;
        repeat (1100) edge_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
